turn_controller: RTL

- Game sequencer for the Connect-4 design. Sits between the two input decoders (local `lrp_self`, remote `lrp_opponent`) and the board memory / win checker.
- Decides whose turn it is, moves the shared drop cursor, and validates puts against column heights.
- Issues a board write through a valid/ready handshake, waits for the win-check result, then swaps turns or ends the game.

---
 rtl/c4_pkg.sv | 37 +++
 rtl/column_heights.sv | 64 ++++++
 rtl/turn_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/c4_pkg.sv
// Shared definitions for the Connect-4 game sequencer.
//   DEF_COLS / DEF_ROWS : default board geometry
//   LRP_*               : bit positions inside a left/right/put move vector
//   state_t             : turn_controller FSM states
//   player_t            : disc owner / whose turn it is
//   winner_t            : game result encoding
package c4_pkg;

  localparam int unsigned DEF_COLS = 7;
  localparam int unsigned DEF_ROWS = 6;

  localparam int unsigned LRP_LEFT  = 2;
  localparam int unsigned LRP_RIGHT = 1;
  localparam int unsigned LRP_PUT   = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TURN  = 3'd1,
    DROP  = 3'd2,
    CHECK = 3'd3,
    SWAP  = 3'd4,
    OVER  = 3'd5
  } state_t;

  typedef enum logic {
    LOCAL = 1'b0,
    OPP   = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LOCAL = 2'b01,
    WIN_OPP   = 2'b10,
    WIN_DRAW  = 2'b11
  } winner_t;

endpackage

// File: rtl/column_heights.sv
// Per-column fill heights of the board.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   clr_i           : clear all heights (new game)
//   inc_i/inc_col_i : add one disc to column inc_col_i
//   rd_col_i        : column to read
//   rd_height_o     : current height of rd_col_i (0 = empty)
//   rd_full_o       : rd_col_i already holds ROWS discs
module column_heights
  import c4_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       inc_i,
  input  logic [$clog2(COLS)-1:0]    inc_col_i,
  input  logic [$clog2(COLS)-1:0]    rd_col_i,
  output logic [$clog2(ROWS+1)-1:0]  rd_height_o,
  output logic                       rd_full_o
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned HW = $clog2(ROWS + 1);

  logic [HW-1:0] height_q [COLS];
  logic [HW-1:0] height_d [COLS];

  always_comb begin
    height_d = height_q;
    for (int c = 0; c < COLS; c++) begin
      if (clr_i) begin
        height_d[c] = '0;
      end else if (inc_i && (inc_col_i == CW'(c)) && (height_q[c] != HW'(ROWS))) begin
        // Saturate at ROWS so a stray increment can never wrap a full column.
        height_d[c] = height_q[c] + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < COLS; c++) begin
        height_q[c] <= '0;
      end
    end else begin
      height_q <= height_d;
    end
  end

  // Mux by comparison so an unused index code reads as empty rather than out of range.
  always_comb begin
    rd_height_o = '0;
    for (int c = 0; c < COLS; c++) begin
      if (rd_col_i == CW'(c)) begin
        rd_height_o = height_q[c];
      end
    end
  end

  assign rd_full_o = (rd_height_o == HW'(ROWS));

endmodule

// File: rtl/turn_controller.sv
// Connect-4 game sequencer: decodes the active player's move pulses, moves the
// shared cursor, validates puts, issues the board write and reacts to the win check.
//   clk, rst            : clock, synchronous active-high reset
//   start, local_first  : new-game pulse and first-mover select
//   lrp_self/opponent   : {left, right, put} one-cycle move pulses
//   turn, cursor        : player to move, selected column
//   wr_*                : valid/ready board write (col, row, player)
//   chk_done, chk_win   : win-checker result
//   game_over, winner   : end-of-game status
//   illegal_put         : pulse after a put into a full column
module turn_controller
  import c4_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    local_first,
  input  logic [2:0]              lrp_self,
  input  logic [2:0]              lrp_opponent,
  output logic                    turn,
  output logic [$clog2(COLS)-1:0] cursor,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [$clog2(COLS)-1:0] wr_col,
  output logic [$clog2(ROWS)-1:0] wr_row,
  output logic                    wr_player,
  input  logic                    chk_done,
  input  logic                    chk_win,
  output logic                    game_over,
  output logic [1:0]              winner,
  output logic                    illegal_put
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned HW = $clog2(ROWS + 1);
  localparam int unsigned MW = $clog2(ROWS * COLS + 1);

  localparam logic [CW-1:0] CursorMid = CW'(COLS / 2);
  localparam logic [CW-1:0] CursorMax = CW'(COLS - 1);
  localparam logic [MW-1:0] MovesMax  = MW'(ROWS * COLS);

  state_t          state_q, state_d;
  player_t         turn_q, turn_d;
  logic [CW-1:0]   cursor_q, cursor_d;
  logic [CW-1:0]   wr_col_q, wr_col_d;
  logic [RW-1:0]   wr_row_q, wr_row_d;
  logic [MW-1:0]   move_cnt_q, move_cnt_d;
  winner_t         winner_q, winner_d;
  logic            illegal_q, illegal_d;

  logic            heights_clr, heights_inc;
  logic [HW-1:0]   cur_height;
  logic            cur_full;
  logic [2:0]      mv;

  column_heights #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_heights (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (heights_clr),
    .inc_i       (heights_inc),
    .inc_col_i   (wr_col_q),
    .rd_col_i    (cursor_q),
    .rd_height_o (cur_height),
    .rd_full_o   (cur_full)
  );

  // Only the player whose turn it is gets decoded.
  assign mv = (turn_q == OPP) ? lrp_opponent : lrp_self;

  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    cursor_d    = cursor_q;
    wr_col_d    = wr_col_q;
    wr_row_d    = wr_row_q;
    move_cnt_d  = move_cnt_q;
    winner_d    = winner_q;
    illegal_d   = 1'b0;
    heights_clr = 1'b0;
    heights_inc = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          turn_d      = local_first ? LOCAL : OPP;
          cursor_d    = CursorMid;
          move_cnt_d  = '0;
          winner_d    = WIN_NONE;
          heights_clr = 1'b1;
          state_d     = TURN;
        end
      end
      TURN: begin
        if (mv[LRP_PUT]) begin
          // Put wins over left/right and uses the cursor before any move.
          if (cur_full) begin
            illegal_d = 1'b1;
          end else begin
            wr_col_d = cursor_q;
            wr_row_d = cur_height[RW-1:0];
            state_d  = DROP;
          end
        end else if (mv[LRP_LEFT] && !mv[LRP_RIGHT]) begin
          if (cursor_q != '0) cursor_d = cursor_q - CW'(1);
        end else if (mv[LRP_RIGHT] && !mv[LRP_LEFT]) begin
          if (cursor_q != CursorMax) cursor_d = cursor_q + CW'(1);
        end
      end
      DROP: begin
        if (wr_ready) begin
          heights_inc = 1'b1;
          move_cnt_d  = move_cnt_q + MW'(1);
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (chk_done) begin
          if (chk_win) begin
            winner_d = (turn_q == OPP) ? WIN_OPP : WIN_LOCAL;
            state_d  = OVER;
          end else if (move_cnt_q == MovesMax) begin
            winner_d = WIN_DRAW;
            state_d  = OVER;
          end else begin
            state_d = SWAP;
          end
        end
      end
      SWAP: begin
        turn_d   = (turn_q == OPP) ? LOCAL : OPP;
        cursor_d = CursorMid;
        state_d  = TURN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      turn_q     <= LOCAL;
      cursor_q   <= CursorMid;
      wr_col_q   <= '0;
      wr_row_q   <= '0;
      move_cnt_q <= '0;
      winner_q   <= WIN_NONE;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      cursor_q   <= cursor_d;
      wr_col_q   <= wr_col_d;
      wr_row_q   <= wr_row_d;
      move_cnt_q <= move_cnt_d;
      winner_q   <= winner_d;
      illegal_q  <= illegal_d;
    end
  end

  assign turn        = turn_q;
  assign cursor      = cursor_q;
  assign wr_valid    = (state_q == DROP);
  assign wr_col      = wr_col_q;
  assign wr_row      = wr_row_q;
  assign wr_player   = turn_q;
  assign game_over   = (state_q == OVER);
  assign winner      = winner_q;
  assign illegal_put = illegal_q;

endmodule
